mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage of the d16 pipeline. Consumes the ALU stage outputs: result/address, store data, register-write flag and opcode.
- LD, ST, PUSH and POP become single data-bus transactions using a req/ack handshake. All other opcodes pass straight through.
- Produces the register writeback value and enable, and a busy signal that stalls the control unit.
- Flags misaligned word accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: wait cycles allowed without mem_ack before the access is aborted with a fault.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage strobe; new operation presented this cycle
- alu_control  in  8  opcode (OPC_* from cpu_constants.vh)
- byte_op  in  1  1 = byte access for LD/ST
- alu_out  in  16  ALU result; the address for LD/ST/PUSH/POP
- alu_mem_data  in  16  store data from the ALU (ST/PUSH)
- alu_write  in  1  ALU register-write flag
- mem_addr  out  16  bus address, word-aligned for word accesses
- mem_wdata  out  16  bus write data
- mem_be  out  2  byte enables: [0] = low byte (even address), [1] = high byte
- mem_we  out  1  1 = write cycle
- mem_req  out  1  bus request
- mem_ack  in  1  bus acknowledge; read data valid in the same cycle
- mem_rdata  in  16  bus read data
- wb_data  out  16  writeback value
- wb_en  out  1  writeback enable, one-cycle pulse
- busy  out  1  stage occupied; control unit must hold en low
- fault  out  1  one-cycle pulse on misalignment or timeout
- fault_code  out  2  0 none, 1 misaligned, 2 timeout; held until the next fault or reset

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset asserted mid-transaction drops mem_req immediately (asynchronous reset) and abandons the access; no writeback.
- States: IDLE, REQ, DONE.
- IDLE, en=1, non-memory opcode:
  - next cycle wb_data=alu_out, wb_en=alu_write, busy=0.
  - Latency 1; back-to-back en is accepted every cycle.
- IDLE, en=1, memory opcode (LD/ST/PUSH/POP), aligned:
  - busy=1 combinationally in that cycle.
  - Address, data and enables are registered; go to REQ; mem_req=1 from the next cycle.
  - mem_we=1 for ST/PUSH, 0 for LD/POP.
  - PUSH/POP are always word accesses; byte_op is ignored for them.
- Misalignment: a word access with alu_out[0]=1 issues no bus cycle.
  - Next cycle: fault=1, fault_code=1, wb_en=0, busy=0.
- REQ:
  - mem_addr, mem_wdata, mem_be and mem_we are held stable while mem_req=1.
  - Each cycle with mem_ack=0 increments the counter.
  - When the counter reaches TIMEOUT_CYCLES: drop mem_req, fault=1, fault_code=2, return to IDLE, no writeback.
  - When mem_ack=1 is sampled: capture mem_rdata, drop mem_req the next cycle, go to DONE.
- DONE (one cycle):
  - LD/POP: wb_en=1 with the load data.
  - ST/PUSH: wb_en=alu_write, which is 0 for ST and PUSH.
  - busy=0; back to IDLE; the counter clears.
  - Minimum memory latency: en at cycle 0, mem_req at cycle 1, ack at cycle 1, wb at cycle 2.
- Byte store: mem_wdata={alu_mem_data[7:0], alu_mem_data[7:0]}; mem_be=01 if addr[0]=0, 10 if addr[0]=1; mem_addr=alu_out.
- Byte load: zero-extend mem_rdata[7:0] when addr[0]=0, mem_rdata[15:8] when addr[0]=1.
- Word access: mem_be=11.
- en=1 while busy: ignored, no state change. Asserting it is a control-unit protocol violation.
- mem_ack while not in REQ: ignored.
- Ack arriving in the same cycle the counter hits its limit: the ack wins; no fault.

Decomposition:
- Add to cpu_constants.vh:
  - MEM_ST_IDLE/REQ/DONE state encodings
  - MEM_FAULT_NONE/MISALIGN/TIMEOUT codes
  - an is_mem_op opcode-set macro covering OPC_LD/ST/PUSH/POP
- Sub-module mem_byte_lane, combinational: store-data replication, byte-enable generation and load extraction/zero-extension, keyed on byte_op and addr[0].

Test Plan:
- OPC_ADD, alu_out=16'h1234, alu_write=1 -> next cycle wb_data=16'h1234, wb_en=1, mem_req never asserted.
- OPC_LD word, alu_out=16'h0100, ack after 3 cycles with rdata=16'hBEEF -> mem_addr=16'h0100, mem_be=11, mem_we=0 held 3 cycles; wb_data=16'hBEEF, wb_en=1 one cycle after the ack.
- OPC_ST byte, alu_out=16'h0201, alu_mem_data=16'h00A5 -> mem_wdata=16'hA5A5, mem_be=10, mem_we=1; on DONE wb_en=0.
- OPC_LD byte, alu_out=16'h0201, rdata=16'h7F33 -> wb_data=16'h007F.
- OPC_PUSH, alu_out=16'h0FFF -> no mem_req; fault pulse, fault_code=1, busy low next cycle.
- OPC_POP, ack never arrives, TIMEOUT_CYCLES=4 -> mem_req drops after 4 wait cycles, fault_code=2. Repeat with rst_n pulsed low mid-REQ -> mem_req goes 0 asynchronously and no wb_en.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the d16 memory stage: FSM encoding, fault codes,
// the opcode values it decodes and the memory-opcode set.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] MEM_FAULT_NONE     = 2'd0;
  localparam logic [1:0] MEM_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] MEM_FAULT_TIMEOUT  = 2'd2;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_AND  = 8'h03;
  localparam logic [7:0] OPC_OR   = 8'h04;
  localparam logic [7:0] OPC_LD   = 8'h20;
  localparam logic [7:0] OPC_ST   = 8'h21;
  localparam logic [7:0] OPC_PUSH = 8'h22;
  localparam logic [7:0] OPC_POP  = 8'h23;

  function automatic logic is_mem_op(input logic [7:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ST) || (opc == OPC_PUSH) || (opc == OPC_POP);
  endfunction

  function automatic logic is_store_op(input logic [7:0] opc);
    return (opc == OPC_ST) || (opc == OPC_PUSH);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the memory stage: store-data replication, byte
// enables and load extraction with zero-extension, keyed on size and addr[0].
module mem_byte_lane (
  input  logic        byte_op,
  input  logic        addr_lsb,
  input  logic [15:0] store_data,
  input  logic [15:0] rdata,
  output logic [15:0] wdata,
  output logic [1:0]  be,
  output logic [15:0] load_data
);

  always_comb begin
    wdata     = store_data;
    be        = 2'b11;
    load_data = rdata;
    if (byte_op) begin
      // Both lanes carry the byte so the enable alone selects the target.
      wdata = {store_data[7:0], store_data[7:0]};
      be    = addr_lsb ? 2'b10 : 2'b01;
      load_data = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// d16 memory stage: turns LD/ST/PUSH/POP into single req/ack bus cycles,
// passes other opcodes through, and reports misalignment and bus timeouts.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  alu_control,
  input  logic        byte_op,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_mem_data,
  input  logic        alu_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] wb_data,
  output logic        wb_en,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q, wdata_q, wb_data_q;
  logic [1:0]       be_q, fault_code_q;
  logic             we_q, byte_q, load_q, alu_write_q, wb_en_q, fault_q;

  logic        mem_op, eff_byte, misaligned, accept, start;
  logic        in_req, ack_hit, timeout_hit;
  logic        lane_byte, lane_lsb;
  logic [15:0] lane_wdata, lane_load;
  logic [1:0]  lane_be;

  // Handshake: mem_req rises the cycle after acceptance and stays high with
  // address/data/enables frozen until a cycle where mem_ack=1 is sampled
  // (rdata valid that same cycle); mem_req is low the following cycle.
  always_comb begin
    mem_op      = is_mem_op(alu_control);
    eff_byte    = byte_op && ((alu_control == OPC_LD) || (alu_control == OPC_ST));
    misaligned  = mem_op && !eff_byte && alu_out[0];
    in_req      = (state_q == MEM_ST_REQ);
    accept      = en && !in_req;
    start       = accept && mem_op && !misaligned;
    ack_hit     = in_req && mem_ack;
    timeout_hit = in_req && !mem_ack && (cnt_q == CNT_LAST);
    lane_byte   = in_req ? byte_q : eff_byte;
    lane_lsb    = in_req ? addr_q[0] : alu_out[0];
  end

  mem_byte_lane u_lane (
    .byte_op    (lane_byte),
    .addr_lsb   (lane_lsb),
    .store_data (alu_mem_data),
    .rdata      (mem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MEM_ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_ST_IDLE,
      MEM_ST_DONE: state_d = start ? MEM_ST_REQ : MEM_ST_IDLE;
      MEM_ST_REQ: begin
        if (ack_hit)          state_d = MEM_ST_DONE;
        else if (timeout_hit) state_d = MEM_ST_IDLE;
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      load_q       <= 1'b0;
      alu_write_q  <= 1'b0;
      wb_data_q    <= '0;
      wb_en_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= MEM_FAULT_NONE;
    end else begin
      wb_en_q <= 1'b0;
      fault_q <= 1'b0;

      if (in_req && !mem_ack && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
      else                                    cnt_q <= '0;

      if (start) begin
        addr_q      <= alu_out;
        wdata_q     <= lane_wdata;
        be_q        <= lane_be;
        we_q        <= is_store_op(alu_control);
        byte_q      <= eff_byte;
        load_q      <= !is_store_op(alu_control);
        alu_write_q <= alu_write;
      end else if (accept && misaligned) begin
        fault_q      <= 1'b1;
        fault_code_q <= MEM_FAULT_MISALIGN;
      end else if (accept) begin
        wb_data_q <= alu_out;
        wb_en_q   <= alu_write;
      end

      if (ack_hit) begin
        wb_en_q   <= load_q || alu_write_q;
        wb_data_q <= load_q ? lane_load : addr_q;
      end

      if (timeout_hit) begin
        fault_q      <= 1'b1;
        fault_code_q <= MEM_FAULT_TIMEOUT;
      end
    end
  end

  always_comb begin
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_be     = be_q;
    mem_we     = we_q;
    mem_req    = in_req;
    wb_data    = wb_data_q;
    wb_en      = wb_en_q;
    busy       = in_req || start;
    fault      = fault_q;
    fault_code = fault_code_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, back-to-back
// pass-through, randomized memory ops and an asynchronous reset mid-access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, byte_op, alu_write, mem_ack;
  logic [7:0]  alu_control;
  logic [15:0] alu_out, alu_mem_data, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [1:0]  mem_be, fault_code;
  logic        mem_we, mem_req, wb_en, busy, fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  exp_code = 2'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alu_control(alu_control),
    .byte_op(byte_op), .alu_out(alu_out), .alu_mem_data(alu_mem_data),
    .alu_write(alu_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_data(wb_data), .wb_en(wb_en), .busy(busy),
    .fault(fault), .fault_code(fault_code)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic exp_en);
    check({tag, "_wb_en"}, wb_en, exp_en);
    if (exp_en) begin
      if (exp_q.size() == 0) check({tag, "_wb_queue"}, 1, 0);
      else check({tag, "_wb_data"}, wb_data, exp_q.pop_front());
    end
  endtask

  // One operation, starting and ending at a negedge. delay = number of
  // no-ack REQ cycles before ack; delay >= TO means the ack never comes.
  task automatic run_op(input logic [7:0] opc, input logic bop, input logic [15:0] addr,
                        input logic [15:0] data, input logic wr, input int delay,
                        input logic [15:0] rdata);
    logic        is_mem, is_wr, eff_b, mis;
    logic [1:0]  be;
    logic [15:0] wd, ld;
    is_mem = opc inside {OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};
    is_wr  = (opc == OPC_ST) || (opc == OPC_PUSH);
    eff_b  = bop && ((opc == OPC_LD) || (opc == OPC_ST));
    mis    = is_mem && !eff_b && addr[0];
    be     = !eff_b ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    wd     = eff_b ? {2{data[7:0]}} : data;
    ld     = eff_b ? ((rdata >> (addr[0] ? 8 : 0)) & 16'h00FF) : rdata;

    en = 1'b1; alu_control = opc; byte_op = bop; alu_out = addr;
    alu_mem_data = data; alu_write = wr;
    mem_ack = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (is_mem && !mis) check("busy_comb", busy, 1);
    @(negedge clk);
    en = 1'b0; alu_control = OPC_NOP; mem_ack = 1'b0;
    alu_out = 16'($urandom); alu_mem_data = 16'($urandom); byte_op = 1'($urandom);

    if (!is_mem) begin
      if (wr) exp_q.push_back(addr);
      check_wb("pass", wr);
      check("pass_req", mem_req, 0);
      check("pass_busy", busy, 0);
      check("pass_fault", fault, 0);
      check("pass_code_held", fault_code, exp_code);
    end else if (mis) begin
      exp_code = 2'd1;
      check("mis_fault", fault, 1);
      check("mis_code", fault_code, 1);
      check("mis_wb_en", wb_en, 0);
      check("mis_busy", busy, 0);
      check("mis_req", mem_req, 0);
    end else begin
      for (int i = 0; i <= TO; i++) begin
        if (i == TO) begin
          exp_code = 2'd2;
          check("to_req", mem_req, 0);
          check("to_fault", fault, 1);
          check("to_code", fault_code, 2);
          check("to_wb_en", wb_en, 0);
          check("to_busy", busy, 0);
          break;
        end
        check("req_req", mem_req, 1);
        check("req_addr", mem_addr, addr);
        check("req_be", mem_be, be);
        check("req_we", mem_we, is_wr);
        check("req_busy", busy, 1);
        if (is_wr) check("req_wdata", mem_wdata, wd);
        if (i == delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          if (!is_wr) exp_q.push_back(ld);
          @(negedge clk);
          mem_ack = 1'b0; mem_rdata = 16'($urandom);
          check("done_req", mem_req, 0);
          check("done_busy", busy, 0);
          check("done_fault", fault, 0);
          check_wb("done", !is_wr || wr);
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    check("pulse_wb_en", wb_en, 0);
    check("pulse_fault", fault, 0);
  endtask

  initial begin
    logic [7:0] opcs[7];
    logic [7:0] opc;
    logic       wr;
    opcs = '{OPC_ADD, OPC_SUB, OPC_OR, OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};

    // reset
    rst_n = 1'b0; en = 1'b0; alu_control = OPC_NOP; byte_op = 1'b0;
    alu_out = '0; alu_mem_data = '0; alu_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_we", mem_we, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed
    run_op(OPC_ADD,  1'b0, 16'h1234, 16'h0000, 1'b1, 0,    16'h0000);
    run_op(OPC_LD,   1'b0, 16'h0100, 16'h0000, 1'b1, 3,    16'hBEEF);
    run_op(OPC_ST,   1'b1, 16'h0201, 16'h00A5, 1'b0, 1,    16'h0000);
    run_op(OPC_LD,   1'b1, 16'h0201, 16'h0000, 1'b1, 0,    16'h7F33);
    run_op(OPC_LD,   1'b1, 16'h0200, 16'h0000, 1'b1, 2,    16'h7F33);
    run_op(OPC_PUSH, 1'b1, 16'h0FFF, 16'h5555, 1'b0, 0,    16'h0000);
    run_op(OPC_SUB,  1'b0, 16'h00FF, 16'h0000, 1'b1, 0,    16'h0000);
    run_op(OPC_POP,  1'b0, 16'h0FFE, 16'h0000, 1'b1, 1000, 16'h0000);
    run_op(OPC_PUSH, 1'b0, 16'h0FFE, 16'hCAFE, 1'b0, 0,    16'h0000);

    // back-to-back pass-through
    en = 1'b1; alu_control = OPC_ADD; alu_out = 16'h1111; alu_write = 1'b1;
    @(negedge clk);
    exp_q.push_back(16'h1111);
    check_wb("b2b_a", 1);
    alu_control = OPC_SUB; alu_out = 16'h2222; alu_write = 1'b0;
    @(negedge clk);
    check_wb("b2b_b", 0);
    alu_control = OPC_AND; alu_out = 16'h3333; alu_write = 1'b1;
    @(negedge clk);
    en = 1'b0;
    exp_q.push_back(16'h3333);
    check_wb("b2b_c", 1);
    @(negedge clk);

    // randomized
    for (int n = 0; n < 80; n++) begin
      opc = opcs[$urandom_range(0, 6)];
      wr  = ((opc == OPC_ST) || (opc == OPC_PUSH)) ? 1'b0 : 1'($urandom);
      run_op(opc, 1'($urandom), 16'($urandom), 16'($urandom), wr,
             $urandom_range(0, TO + 1), 16'($urandom));
    end

    // asynchronous reset during REQ
    en = 1'b1; alu_control = OPC_LD; byte_op = 1'b0; alu_out = 16'h0100; alu_write = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("arst_req_before", mem_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_code = 2'd0;
    check("arst_req", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_code", fault_code, 0);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("arst_after_wb_en", wb_en, 0);
    check("arst_after_req", mem_req, 0);
    check("arst_after_fault", fault, 0);
    run_op(OPC_ADD, 1'b0, 16'hABCD, 16'h0000, 1'b1, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
